// File: rtl/ad_capture_pkg.sv
// =====================================================================
// ad_capture_pkg -- shared types and helpers for the ADC capture path
// Rev 1.0
// =====================================================================
`default_nettype none

package ad_capture_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DRAIN   = 2'd3
   } state_e;

   localparam logic [1:0] TRIG_IMM  = 2'd0;
   localparam logic [1:0] TRIG_RISE = 2'd1;
   localparam logic [1:0] TRIG_FALL = 2'd2;
   localparam logic [1:0] TRIG_EXT  = 2'd3;

   // Sign-magnitude mV to two's complement; -0 and +0 both map to zero.
   function automatic logic signed [16:0] sm_to_s17(input logic [15:0] v);
      logic signed [16:0] mag;
      mag = signed'({2'b00, v[14:0]});
      return v[15] ? -mag : mag;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ad_pair_fifo.sv
// =====================================================================
// ad_pair_fifo -- 2-entry synchronous FIFO for captured ch1/ch2 pairs
// Rev 1.0
// =====================================================================
`default_nettype none

module ad_pair_fifo #(
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic              flush_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] data_o,
   output logic              full_o,
   output logic              empty_o
);

   logic [DATA_W-1:0] mem_q [2];
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [1:0]        count_q, count_d;
   logic              push_ok, pop_ok;

   assign full_o  = (count_q == 2'd2);
   assign empty_o = (count_q == 2'd0);
   assign pop_ok  = pop_i & ~empty_o;
   // When full, a same-cycle pop frees the slot the write pointer aims at.
   assign push_ok = push_i & (~full_o | pop_ok);
   assign data_o  = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (push_ok) wr_ptr_d = ~wr_ptr_q;
         if (pop_ok)  rd_ptr_d = ~rd_ptr_q;
         count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_ok && !flush_i) mem_q[wr_ptr_q] <= data_i;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/ad_capture_ctrl.sv
// =====================================================================
// ad_capture_ctrl -- armed/triggered decimating capture of ch1/ch2 pairs
// Rev 1.0
// =====================================================================
`default_nettype none

module ad_capture_ctrl
   import ad_capture_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int DIV_W = 16
) (
   input  logic              ad_clk,
   input  logic              rst_n,
   input  logic [15:0]       volt_ch1,
   input  logic [15:0]       volt_ch2,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic [CNT_W-1:0]  cfg_len,
   input  logic [1:0]        cfg_mode,
   input  logic [15:0]       cfg_thresh,
   input  logic              start,
   input  logic              abort,
   input  logic              ext_trig,
   output logic [31:0]       out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done,
   output logic              overrun
);

   state_e             state_q, state_d;
   logic [DIV_W-1:0]   div_q, div_d, dec_q, dec_d;
   logic [CNT_W-1:0]   len_q, len_d, cnt_q, cnt_d;
   logic [1:0]         mode_q, mode_d;
   logic signed [16:0] thr_q, thr_d, prev_q, prev_d;
   logic               prev_valid_q, prev_valid_d;
   logic               overrun_q, overrun_d;
   logic               done_q, done_d;

   logic signed [16:0] cur_ch1;
   logic               trig, push_sched, drop;
   logic               fifo_pop, fifo_full, fifo_empty;

   assign cur_ch1  = sm_to_s17(volt_ch1);
   assign fifo_pop = ~fifo_empty & out_ready;

   always_comb begin
      state_d      = state_q;
      div_d        = div_q;
      len_d        = len_q;
      mode_d       = mode_q;
      thr_d        = thr_q;
      dec_d        = dec_q;
      cnt_d        = cnt_q;
      prev_d       = prev_q;
      prev_valid_d = prev_valid_q;
      overrun_d    = overrun_q;
      done_d       = 1'b0;
      push_sched   = 1'b0;
      trig         = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start && !abort && (cfg_len != '0)) begin
               state_d      = ST_ARMED;
               div_d        = cfg_div;
               len_d        = cfg_len;
               mode_d       = cfg_mode;
               thr_d        = sm_to_s17(cfg_thresh);
               cnt_d        = '0;
               dec_d        = '0;
               prev_valid_d = 1'b0;
               overrun_d    = 1'b0;
            end
         end
         ST_ARMED: begin
            prev_d       = cur_ch1;
            prev_valid_d = 1'b1;
            case (mode_q)
               TRIG_IMM:  trig = 1'b1;
               TRIG_RISE: trig = prev_valid_q && (prev_q < thr_q) && (cur_ch1 >= thr_q);
               TRIG_FALL: trig = prev_valid_q && (prev_q > thr_q) && (cur_ch1 <= thr_q);
               TRIG_EXT:  trig = ext_trig;
               default:   trig = 1'b0;
            endcase
            if (trig) begin
               push_sched = 1'b1;
               dec_d      = '0;
               cnt_d      = CNT_W'(1);
               state_d    = (len_q == CNT_W'(1)) ? ST_DRAIN : ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            if (dec_q == div_q) begin
               dec_d      = '0;
               push_sched = 1'b1;
               cnt_d      = cnt_q + 1'b1;
               if (cnt_d == len_q) state_d = ST_DRAIN;
            end else begin
               dec_d = dec_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            // Finish on the same edge the last beat is handshaken.
            if (fifo_empty || (!fifo_full && fifo_pop)) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (abort) begin
         state_d    = ST_IDLE;
         done_d     = 1'b0;
         push_sched = 1'b0;
      end

      drop = push_sched && fifo_full && !fifo_pop;
      if (drop) overrun_d = 1'b1;
   end

   always_ff @(posedge ad_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         div_q        <= '0;
         len_q        <= '0;
         mode_q       <= TRIG_IMM;
         thr_q        <= '0;
         dec_q        <= '0;
         cnt_q        <= '0;
         prev_q       <= '0;
         prev_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         div_q        <= div_d;
         len_q        <= len_d;
         mode_q       <= mode_d;
         thr_q        <= thr_d;
         dec_q        <= dec_d;
         cnt_q        <= cnt_d;
         prev_q       <= prev_d;
         prev_valid_q <= prev_valid_d;
         overrun_q    <= overrun_d;
         done_q       <= done_d;
      end
   end

   ad_pair_fifo #(
      .DATA_W (32)
   ) u_fifo (
      .clk_i   (ad_clk),
      .rst_ni  (rst_n),
      .push_i  (push_sched),
      .pop_i   (fifo_pop),
      .flush_i (abort),
      .data_i  ({volt_ch1, volt_ch2}),
      .data_o  (out_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign out_valid = ~fifo_empty;
   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign overrun   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_ad_capture_ctrl.sv
// =====================================================================
// tb_ad_capture_ctrl -- scoreboard bench for the capture sequencer
// Rev 1.0
// =====================================================================
`default_nettype none

module tb_ad_capture_ctrl;

   logic        ad_clk;
   logic        rst_n;
   logic [15:0] volt_ch1, volt_ch2;
   logic [15:0] cfg_div, cfg_len, cfg_thresh;
   logic [1:0]  cfg_mode;
   logic        start, abort, ext_trig;
   logic [31:0] out_data;
   logic        out_valid, out_ready;
   logic        busy, done, overrun;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          last_beat_cyc = -10;
   int          done_cnt = 0;
   int          done_cyc = 0;
   logic        done_busy = 1'b0;
   logic        prev_done = 1'b0;
   logic        hold_v = 1'b0;
   logic [31:0] hold_d = '0;
   logic [31:0] exp_q [$];

   ad_capture_ctrl #(.CNT_W(16), .DIV_W(16)) dut (
      .ad_clk     (ad_clk),
      .rst_n      (rst_n),
      .volt_ch1   (volt_ch1),
      .volt_ch2   (volt_ch2),
      .cfg_div    (cfg_div),
      .cfg_len    (cfg_len),
      .cfg_mode   (cfg_mode),
      .cfg_thresh (cfg_thresh),
      .start      (start),
      .abort      (abort),
      .ext_trig   (ext_trig),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy),
      .done       (done),
      .overrun    (overrun)
   );

   initial ad_clk = 1'b0;
   always #5 ad_clk = ~ad_clk;

   always @(posedge ad_clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Output side: pop the scoreboard on each handshake, watch stability and done.
   always @(negedge ad_clk) begin
      logic [31:0] want;
      if (rst_n) begin
         if (hold_v && out_valid) chk("stable", out_data, hold_d);
         if (out_valid && out_ready) begin
            if (exp_q.size() != 0) want = exp_q.pop_front();
            else                   want = ~out_data;
            chk("beat", out_data, want);
            last_beat_cyc = cyc;
         end
         if (done) begin
            chk("done_width", 32'(prev_done), 32'd0);
            done_cnt++;
            done_cyc  = cyc;
            done_busy = busy;
         end
         prev_done = done;
         hold_v    = out_valid && !out_ready;
         hold_d    = out_data;
      end
   end

   task automatic tick();
      @(posedge ad_clk);
      #1;
   endtask

   task automatic arm(input logic [1:0] mode, input logic [15:0] div,
                      input logic [15:0] len, input logic [15:0] thr);
      cfg_mode   = mode;
      cfg_div    = div;
      cfg_len    = len;
      cfg_thresh = thr;
      start      = 1'b1;
      tick();
      start      = 1'b0;
   endtask

   task automatic drv(input logic [15:0] c1, input logic [15:0] c2, input bit keep);
      volt_ch1 = c1;
      volt_ch2 = c2;
      if (keep) exp_q.push_back({c1, c2});
      tick();
   endtask

   task automatic wait_done(input int d0);
      int n;
      n = 0;
      while (done_cnt == d0 && n < 300) begin
         @(negedge ad_clk);
         n++;
      end
      chk("done_seen", 32'(done_cnt - d0), 32'd1);
      chk("done_lat", 32'(done_cyc), 32'(last_beat_cyc + 1));
      chk("busy_at_done", 32'(done_busy), 32'd0);
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      tick();
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      rst_n = 1'b0; volt_ch1 = '0; volt_ch2 = '0;
      cfg_div = '0; cfg_len = '0; cfg_thresh = '0; cfg_mode = 2'd0;
      start = 1'b0; abort = 1'b0; ext_trig = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge ad_clk);
      chk("rst_data", out_data, 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      cfg_len = 16'd0; start = 1'b1; tick(); start = 1'b0;
      @(negedge ad_clk);
      chk("len0_ignored", 32'(busy), 32'd0);
      tick();

      // Immediate capture with a ramp; cfg changes after start must not matter.
      out_ready = 1'b1; d0 = done_cnt;
      arm(2'd0, 16'd0, 16'd4, 16'd0);
      cfg_len = 16'd9; cfg_mode = 2'd3; cfg_div = 16'd5;
      for (int i = 0; i < 6; i++) drv(16'(i + 1), 16'(16'h2000 + i), i < 4);
      wait_done(d0);

      // Rising through +1000 mV.
      d0 = done_cnt;
      arm(2'd1, 16'd0, 16'd2, 16'h03E8);
      drv(16'h80C8, 16'h3000, 1'b0);
      drv(16'h01F4, 16'h3001, 1'b0);
      drv(16'h04B0, 16'h3002, 1'b1);
      drv(16'h0007, 16'h3003, 1'b1);
      for (int i = 0; i < 3; i++) drv(16'h0009, 16'h3004, 1'b0);
      wait_done(d0);

      // Falling through -100 mV.
      d0 = done_cnt;
      arm(2'd2, 16'd0, 16'd1, 16'h8064);
      drv(16'h0000, 16'h3100, 1'b0);
      drv(16'h8032, 16'h3101, 1'b0);
      drv(16'h8096, 16'h3102, 1'b1);
      for (int i = 0; i < 3; i++) drv(16'h1111, 16'h3103, 1'b0);
      wait_done(d0);

      // -0 must compare equal to +0 threshold.
      d0 = done_cnt;
      arm(2'd1, 16'd0, 16'd1, 16'h0000);
      drv(16'h8001, 16'h3200, 1'b0);
      drv(16'h8000, 16'h3201, 1'b1);
      for (int i = 0; i < 3; i++) drv(16'h0001, 16'h3202, 1'b0);
      wait_done(d0);

      // Decimation by 4.
      d0 = done_cnt;
      arm(2'd0, 16'd3, 16'd3, 16'd0);
      for (int i = 0; i < 12; i++)
         drv(16'(16'h0040 + i), 16'(16'h3300 + i), (i % 4) == 0);
      wait_done(d0);

      // Overrun with a stalled sink.
      out_ready = 1'b0; d0 = done_cnt;
      arm(2'd0, 16'd0, 16'd5, 16'd0);
      for (int i = 0; i < 8; i++) drv(16'(16'h0100 + i), 16'(16'h4000 + i), i < 2);
      @(negedge ad_clk);
      chk("ovr_flag", 32'(overrun), 32'd1);
      chk("ovr_valid", 32'(out_valid), 32'd1);
      chk("ovr_busy", 32'(busy), 32'd1);
      chk("ovr_head", out_data, {16'h0100, 16'h4000});
      tick();
      out_ready = 1'b1;
      wait_done(d0);
      chk("ovr_sticky", 32'(overrun), 32'd1);

      // Abort mid-capture with one pair buffered.
      out_ready = 1'b0; d0 = done_cnt;
      arm(2'd0, 16'd3, 16'd4, 16'd0);
      volt_ch1 = 16'h0AAA; volt_ch2 = 16'h0BBB;
      @(negedge ad_clk);
      chk("start_clr_ovr", 32'(overrun), 32'd0);
      tick();
      drv(16'h0AAB, 16'h0BBC, 1'b0);
      @(negedge ad_clk);
      chk("abort_pre_valid", 32'(out_valid), 32'd1);
      chk("abort_pre_busy", 32'(busy), 32'd1);
      tick();
      abort = 1'b1; tick(); abort = 1'b0;
      @(negedge ad_clk);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_valid", 32'(out_valid), 32'd0);
      tick();
      out_ready = 1'b1;
      repeat (4) tick();
      chk("abort_no_done", 32'(done_cnt), 32'(d0));

      cfg_len = 16'd2; start = 1'b1; abort = 1'b1; tick();
      start = 1'b0; abort = 1'b0;
      @(negedge ad_clk);
      chk("start_abort_idle", 32'(busy), 32'd0);
      tick();

      d0 = done_cnt;
      arm(2'd0, 16'd0, 16'd1, 16'd0);
      drv(16'h0ABC, 16'h0DEF, 1'b1);
      for (int i = 0; i < 3; i++) drv(16'h0001, 16'h0002, 1'b0);
      wait_done(d0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ad_capture_ctrl.md
Name: ad_capture_ctrl

Overview:
Capture sequencer for the dual-channel ADC voltage path. It consumes the per-cycle millivolt samples from the ADC conversion block, arms on command, and waits for a trigger (immediate, ch1 threshold crossing or external). It then captures a programmed number of decimated ch1/ch2 sample pairs. Pairs go through a 2-entry buffer and leave over a valid/ready stream toward the host/communication logic.

Parameters:
CNT_W, 16, width of capture-length and sample counters
DIV_W, 16, width of decimation divider

Ports:
ad_clk  in  1  ADC sample clock (65 MHz); all logic on rising edge
rst_n  in  1  asynchronous active-low reset
volt_ch1  in  16  ch1 sample, sign-magnitude mV: bit15 = sign (1 = negative), bits14:0 = magnitude; new value every cycle
volt_ch2  in  16  ch2 sample, same format
cfg_div  in  DIV_W  decimation: keep 1 sample every cfg_div+1 cycles
cfg_len  in  CNT_W  number of pairs to capture; 0 = start ignored
cfg_mode  in  2  trigger: 0 immediate, 1 ch1 rising through threshold, 2 ch1 falling through threshold, 3 ext_trig
cfg_thresh  in  16  threshold, sign-magnitude mV
start  in  1  arm request, single-cycle pulse
abort  in  1  cancel capture
ext_trig  in  1  external trigger level, already synchronous to ad_clk
out_data  out  32  {ch1, ch2}
out_valid  out  1  pair available
out_ready  in  1  downstream accepts
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on normal completion
overrun  out  1  sticky: a sample was dropped because the buffer was full

Behaviour:
- Reset: state IDLE; counters and buffer cleared; out_data = 0; out_valid, busy, done and overrun = 0.
- Config is latched when start is accepted. Later changes to cfg_* have no effect until the next start.
- States: IDLE, ARMED, CAPTURE, DRAIN.
- IDLE: start=1, abort=0 and cfg_len!=0 → ARMED next cycle. Accepting start also clears overrun, the sample counter and prev_valid.
- ARMED: the trigger is evaluated every cycle on the current volt_ch1 and a registered previous sample.
  - Mode 0 triggers on the first ARMED cycle.
  - Mode 1 fires when prev < thresh and cur >= thresh.
  - Mode 2 fires when prev > thresh and cur <= thresh.
  - Mode 3 fires when ext_trig=1.
  - Modes 1 and 2 require prev_valid, which is set after the first ARMED cycle, so there is no crossing on the first cycle.
- Compare arithmetic: both operands are converted to 17-bit two's complement (magnitude, negated if sign=1); -0 equals +0.
- Trigger cycle: that cycle's {volt_ch1, volt_ch2} is pushed as pair 1 and the decimation counter is reset to 0. Next state is CAPTURE, or DRAIN if cfg_len = 1.
- CAPTURE:
  - The decimation counter counts 0..cfg_div and pushes a pair when it wraps to 0. With cfg_div = 0, every cycle pushes.
  - The sample counter increments on each scheduled push, dropped or not.
  - Reaching cfg_len → DRAIN on the following cycle.
- Buffer full at a scheduled push with no pop in the same cycle → the pair is dropped and overrun is set. A push and a pop in the same cycle while full is accepted.
- DRAIN: waits until the buffer is empty (last beat handshaken). It then pulses done for 1 cycle, concurrently with the return to IDLE.
- Output stream:
  - out_valid = buffer non-empty; out_data = head entry.
  - The transfer occurs on out_valid & out_ready.
  - out_data must be stable while out_valid=1 and out_ready=0.
  - Latency from push to out_valid is 1 cycle.
- abort: from any state → IDLE next cycle; buffer flushed, out_valid drops next cycle, no done pulse, overrun keeps its value. If start and abort occur in the same cycle, abort wins. start while busy is ignored.
- Counter wrap: no wrap occurs, because the sample counter compares against cfg_len before incrementing past it.

Decomposition:
- Package ad_capture_pkg: state enum, trigger-mode constants (TRIG_IMM, TRIG_RISE, TRIG_FALL, TRIG_EXT), and a sign-magnitude to 17-bit signed conversion function.
- One sub-module, ad_pair_fifo: 2-entry, 32-bit synchronous FIFO with push/pop/flush, full/empty, and same-cycle push+pop when full.

Test Plan:
1. Immediate capture: cfg_mode=0, cfg_div=0, cfg_len=4, out_ready=1, ch1 ramping 1,2,3… each cycle → 4 consecutive beats with ch1 = value present on the first ARMED cycle and its 3 successors; done pulses 1 cycle after the last beat; busy drops with done.
2. Rising threshold: cfg_mode=1, cfg_thresh=0x03E8 (+1000 mV), ch1 sequence 0x80C8 (-200), 0x01F4 (+500), 0x04B0 (+1200) → first beat ch1 = 0x04B0; no trigger on 0x01F4.
3. Negative falling threshold: cfg_mode=2, cfg_thresh=0x8064 (-100), ch1 0x0000, 0x8032, 0x8096 → trigger on 0x8096; sign-magnitude compare correct; 0x8000 is treated as equal to 0x0000.
4. Decimation: cfg_div=3, cfg_len=3, mode 0 → pairs sampled on trigger cycle T, T+4 and T+8 only.
5. Overrun: cfg_div=0, cfg_len=5, out_ready=0 during capture → buffer holds pairs 1–2 and overrun=1; after out_ready=1 exactly 2 beats (pairs 1, 2) are delivered, then done.
6. Abort: abort asserted mid-CAPTURE with 1 pair buffered → IDLE next cycle, out_valid=0, no done; a new start is accepted afterwards, and start+abort in the same cycle in IDLE stays IDLE.
